// File: rtl/cheshire_preload_arb.sv
// Preload port arbiter: round-robin with burst locking across JTAG, serial link and UART,
// in-order response routing through an ID FIFO, and an EOC write snoop capturing the exit code.
module cheshire_preload_arb #(
    parameter int unsigned          AddrWidth      = 48,
    parameter int unsigned          DataWidth      = 64,
    parameter int unsigned          MaxOutstanding = 4,
    parameter logic [AddrWidth-1:0] EocAddr        = 48'h0300_0008
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             boot_mode_i,
    input  logic [2:0]             req_i,
    input  logic [2:0]             we_i,
    input  logic [2:0]             last_i,
    input  logic [3*AddrWidth-1:0] addr_i,
    input  logic [3*DataWidth-1:0] wdata_i,
    output logic [2:0]             gnt_o,
    output logic [2:0]             rvalid_o,
    output logic [DataWidth-1:0]   rdata_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [DataWidth-1:0]   mem_rdata_i,
    output logic                   eoc_o,
    output logic [31:0]            exit_code_o,
    output logic                   busy_o
);
    localparam int unsigned PtrW = $clog2(MaxOutstanding);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e          state_q;
    logic [1:0]      owner_q;
    logic [1:0]      rr_ptr_q;
    logic [1:0]      sel;
    logic [1:0]      cand;
    logic            sel_valid;
    logic [2:0]      eligible;
    logic [1:0]      id_mem [MaxOutstanding];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            fifo_full;
    logic            fifo_empty;
    logic            handshake;
    logic            pop;
    logic [1:0]      head;

    // Autonomous boot only lets the JTAG agent (index 0) start new transfers.
    always_comb begin
        eligible  = req_i & ((boot_mode_i != 2'd0) ? 3'b001 : 3'b111);
        sel       = rr_ptr_q;
        sel_valid = 1'b0;
        cand      = 2'd0;
        if (state_q == LOCKED) begin
            sel       = owner_q;
            sel_valid = req_i[owner_q];
        end else begin
            for (int unsigned k = 0; k < 3; k++) begin
                cand = 2'((32'(rr_ptr_q) + k) % 3);
                if (!sel_valid && eligible[cand]) begin
                    sel       = cand;
                    sel_valid = 1'b1;
                end
            end
        end
    end

    assign fifo_full  = (count_q == (PtrW+1)'(MaxOutstanding));
    assign fifo_empty = (count_q == '0);
    assign head       = id_mem[rd_ptr_q];

    assign mem_req_o   = sel_valid & ~fifo_full & ~rst_i;
    assign mem_we_o    = mem_req_o & we_i[sel];
    assign mem_addr_o  = mem_req_o ? addr_i[32'(sel)*AddrWidth +: AddrWidth] : '0;
    assign mem_wdata_o = mem_req_o ? wdata_i[32'(sel)*DataWidth +: DataWidth] : '0;
    assign handshake   = mem_req_o & mem_gnt_i;
    assign gnt_o       = handshake ? 3'(3'b001 << sel) : 3'b000;

    // Stray responses with nothing outstanding are dropped rather than routed.
    assign pop      = mem_rvalid_i & ~fifo_empty & ~rst_i;
    assign rvalid_o = pop ? 3'(3'b001 << head) : 3'b000;
    assign rdata_o  = pop ? mem_rdata_i : '0;
    assign busy_o   = ~rst_i & ((state_q == LOCKED) | ~fifo_empty);

    always_ff @(posedge clk_i) begin
        if (handshake) begin
            id_mem[wr_ptr_q] <= sel;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            owner_q     <= 2'd0;
            rr_ptr_q    <= 2'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            eoc_o       <= 1'b0;
            exit_code_o <= 32'd0;
        end else begin
            if (handshake) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
                if (last_i[sel]) begin
                    state_q  <= IDLE;
                    rr_ptr_q <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
                end else begin
                    state_q <= LOCKED;
                    owner_q <= sel;
                end
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({handshake, pop})
                2'b10:   count_q <= count_q + (PtrW+1)'(1);
                2'b01:   count_q <= count_q - (PtrW+1)'(1);
                default: count_q <= count_q;
            endcase
            // First exit code wins; later EOC writes are ignored until reset.
            if (handshake && mem_we_o && (mem_addr_o == EocAddr) && mem_wdata_o[0] && !eoc_o) begin
                eoc_o       <= 1'b1;
                exit_code_o <= mem_wdata_o[32:1];
            end
        end
    end

    a_mem_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (mem_req_o && !mem_gnt_i) |=> (mem_req_o && $stable(mem_we_o)
                                       && $stable(mem_addr_o) && $stable(mem_wdata_o)));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(handshake && !pop && fifo_full));
    a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
        !(mem_rvalid_i && fifo_empty));
endmodule

// File: tb/tb_cheshire_preload_arb.sv
// Bench for cheshire_preload_arb: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a queue-based behavioural model.
module tb_cheshire_preload_arb;
    localparam int AW = 48;
    localparam int DW = 64;
    localparam int MO = 4;
    localparam logic [AW-1:0] EOC_ADDR = 48'h0300_0008;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [1:0]    boot_mode_i;
    logic [2:0]    req_i, we_i, last_i;
    logic [3*AW-1:0] addr_i;
    logic [3*DW-1:0] wdata_i;
    logic [2:0]    gnt_o, rvalid_o;
    logic [DW-1:0] rdata_o;
    logic          mem_req_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_gnt_i, mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;
    logic          eoc_o;
    logic [31:0]   exit_code_o;
    logic          busy_o;

    cheshire_preload_arb #(
        .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO), .EocAddr(EOC_ADDR)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .boot_mode_i(boot_mode_i),
        .req_i(req_i), .we_i(we_i), .last_i(last_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .eoc_o(eoc_o), .exit_code_o(exit_code_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: pointer, lock owner (-1 = none), queue of outstanding requester ids.
    int          m_ptr   = 0;
    int          m_owner = -1;
    int          m_q[$];
    bit          m_eoc   = 1'b0;
    logic [31:0] m_exit  = 32'd0;

    int          g_sel;
    bit          g_hs, g_pop, g_stall, g_eoc_hit;
    logic [31:0] g_exit;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic clear_reqs();
        req_i = '0; we_i = '0; last_i = '0; addr_i = '0; wdata_i = '0;
    endtask

    task automatic drive_req(input int i, input logic we, input logic last,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_i[i] = 1'b1;
        we_i[i] = we;
        last_i[i] = last;
        addr_i[i*AW +: AW] = a;
        wdata_i[i*DW +: DW] = d;
    endtask

    task automatic compare_model();
        int          sel;
        bit          selv;
        logic        e_req, e_busy;
        logic [2:0]  e_gnt, e_rv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd, e_rd, wd;
        sel = 0;
        selv = 1'b0;
        if (m_owner >= 0) begin
            sel = m_owner;
            selv = req_i[m_owner];
        end else begin
            for (int k = 0; k < 3; k++) begin
                int i;
                i = (m_ptr + k) % 3;
                if (!selv && req_i[i] && (boot_mode_i == 2'd0 || i == 0)) begin
                    sel = i;
                    selv = 1'b1;
                end
            end
        end
        e_req   = !rst_i && selv && (m_q.size() < MO);
        g_hs    = e_req && mem_gnt_i;
        g_stall = e_req && !mem_gnt_i;
        g_sel   = sel;
        wd      = wdata_i[sel*DW +: DW];
        e_gnt   = g_hs ? 3'(1 << sel) : 3'b000;
        e_addr  = e_req ? addr_i[sel*AW +: AW] : '0;
        e_wd    = e_req ? wd : '0;
        g_eoc_hit = g_hs && we_i[sel] && (addr_i[sel*AW +: AW] == EOC_ADDR) && wd[0];
        g_exit  = wd[32:1];
        g_pop   = !rst_i && mem_rvalid_i && (m_q.size() > 0);
        e_rv    = 3'b000;
        e_rd    = '0;
        if (g_pop) begin
            e_rv = 3'(1 << m_q[0]);
            e_rd = mem_rdata_i;
        end
        e_busy = !rst_i && (m_owner >= 0 || m_q.size() > 0);
        chk("gnt", gnt_o, e_gnt);
        chk("mem_req", mem_req_o, e_req);
        chk("mem_we", mem_we_o, e_req && we_i[sel]);
        chk("mem_addr", mem_addr_o, e_addr);
        chk("mem_wdata", mem_wdata_o, e_wd);
        chk("rvalid", rvalid_o, e_rv);
        chk("rdata", rdata_o, e_rd);
        chk("busy", busy_o, e_busy);
        chk("eoc", eoc_o, m_eoc);
        chk("exit_code", exit_code_o, m_exit);
    endtask

    task automatic advance();
        @(posedge clk_i);
        if (rst_i) begin
            m_q.delete();
            m_owner = -1;
            m_ptr = 0;
            m_eoc = 1'b0;
            m_exit = 32'd0;
        end else begin
            if (g_pop) void'(m_q.pop_front());
            if (g_hs) begin
                m_q.push_back(g_sel);
                if (last_i[g_sel]) begin
                    m_owner = -1;
                    m_ptr = (g_sel + 1) % 3;
                end else begin
                    m_owner = g_sel;
                end
            end
            if (g_eoc_hit && !m_eoc) begin
                m_eoc = 1'b1;
                m_exit = g_exit;
            end
        end
        @(negedge clk_i);
    endtask

    task automatic cycle();
        #1;
        compare_model();
        advance();
    endtask

    task automatic drain();
        clear_reqs();
        for (int n = 0; n < 8 && m_q.size() > 0; n++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i = {$urandom, $urandom};
            cycle();
        end
        mem_rvalid_i = 1'b0;
    endtask

    logic [2:0] rr_order [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [2:0] bp_order [4] = '{3'b001, 3'b100, 3'b001, 3'b100};

    initial begin
        logic [63:0] r64;
        rst_i = 1'b1; boot_mode_i = 2'd0; mem_gnt_i = 1'b1;
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        clear_reqs();
        @(posedge clk_i);
        @(negedge clk_i);

        // Reset state
        #1;
        compare_model();
        chk("rst_gnt", gnt_o, 3'b000);
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_eoc", eoc_o, 1'b0);
        chk("rst_exit", exit_code_o, 32'd0);
        advance();
        rst_i = 1'b0;

        // Single UART write
        drive_req(2, 1'b1, 1'b1, 48'h1000_0000, 64'hDEAD_BEEF);
        #1;
        compare_model();
        chk("t1_gnt", gnt_o, 3'b100);
        chk("t1_addr", mem_addr_o, 48'h1000_0000);
        chk("t1_wdata", mem_wdata_o, 64'hDEAD_BEEF);
        chk("t1_we", mem_we_o, 1'b1);
        advance();
        chk("t1_model_ptr", m_ptr, 0);
        clear_reqs();
        mem_rvalid_i = 1'b1;
        mem_rdata_i = 64'h55;
        #1;
        compare_model();
        chk("t1_rvalid", rvalid_o, 3'b100);
        advance();
        mem_rvalid_i = 1'b0;

        // Round-robin fairness
        for (int c = 0; c < 6; c++) begin
            clear_reqs();
            for (int i = 0; i < 3; i++) drive_req(i, 1'b0, 1'b1, 48'(i * 16), 64'(c));
            mem_rvalid_i = (m_q.size() > 0);
            mem_rdata_i = 64'(c);
            #1;
            compare_model();
            chk("rr_gnt", gnt_o, rr_order[c]);
            advance();
        end
        drain();

        // Burst lock: requester 1 holds the port for 4 beats
        drive_req(0, 1'b0, 1'b1, 48'h100, 64'h0);
        cycle();
        for (int b = 0; b < 4; b++) begin
            clear_reqs();
            drive_req(0, 1'b0, 1'b1, 48'h100, 64'h0);
            drive_req(1, 1'b1, (b == 3), 48'(48'h2000 + b * 8), 64'(b));
            mem_rvalid_i = (m_q.size() > 0);
            #1;
            compare_model();
            chk("burst_gnt", gnt_o, 3'b010);
            chk("burst_busy", busy_o, 1'b1);
            advance();
        end
        clear_reqs();
        drive_req(0, 1'b0, 1'b1, 48'h100, 64'h0);
        mem_rvalid_i = (m_q.size() > 0);
        #1;
        compare_model();
        chk("burst_after_gnt", gnt_o, 3'b001);
        advance();
        drain();

        // Backpressure: FIFO fills after 4 reads, then responses route in order
        for (int i = 0; i < 4; i++) begin
            clear_reqs();
            drive_req((i % 2 == 0) ? 0 : 2, 1'b0, 1'b1, 48'(i * 8), 64'h0);
            #1;
            compare_model();
            chk("bp_gnt", gnt_o, bp_order[i]);
            advance();
        end
        clear_reqs();
        drive_req(0, 1'b0, 1'b1, 48'h40, 64'h0);
        #1;
        compare_model();
        chk("bp_full_gnt", gnt_o, 3'b000);
        chk("bp_full_req", mem_req_o, 1'b0);
        advance();
        clear_reqs();
        for (int i = 0; i < 4; i++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i = 64'(i + 1);
            #1;
            compare_model();
            chk("bp_rvalid", rvalid_o, bp_order[i]);
            chk("bp_rdata", rdata_o, 64'(i + 1));
            advance();
        end
        mem_rvalid_i = 1'b0;

        // EOC capture, first code wins
        drive_req(0, 1'b1, 1'b1, EOC_ADDR, 64'h1);
        cycle();
        clear_reqs();
        mem_rvalid_i = 1'b1;
        #1;
        compare_model();
        chk("eoc_set", eoc_o, 1'b1);
        chk("eoc_code", exit_code_o, 32'd0);
        advance();
        mem_rvalid_i = 1'b0;
        drive_req(0, 1'b1, 1'b1, EOC_ADDR, 64'h7);
        cycle();
        clear_reqs();
        mem_rvalid_i = 1'b1;
        #1;
        compare_model();
        chk("eoc_sticky_code", exit_code_o, 32'd0);
        advance();
        mem_rvalid_i = 1'b0;

        // Boot-mode gating, then reset mid-burst
        boot_mode_i = 2'd2;
        drive_req(1, 1'b0, 1'b1, 48'h10, 64'h0);
        drive_req(2, 1'b0, 1'b1, 48'h20, 64'h0);
        #1;
        compare_model();
        chk("boot_gnt_none", gnt_o, 3'b000);
        advance();
        drive_req(0, 1'b0, 1'b0, 48'h30, 64'h0);
        #1;
        compare_model();
        chk("boot_gnt_0", gnt_o, 3'b001);
        advance();
        cycle();
        clear_reqs();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        boot_mode_i = 2'd0;
        #1;
        compare_model();
        chk("post_rst_busy", busy_o, 1'b0);
        chk("post_rst_gnt", gnt_o, 3'b000);
        chk("post_rst_eoc", eoc_o, 1'b0);
        advance();

        // Random traffic; requester inputs frozen while a request waits for mem_gnt_i
        g_stall = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!g_stall) begin
                rst_i = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 49) == 0)
                    boot_mode_i = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
                req_i  = 3'($urandom_range(0, 7));
                we_i   = 3'($urandom_range(0, 7));
                last_i = 3'($urandom_range(0, 7));
                for (int i = 0; i < 3; i++) begin
                    r64 = {$urandom, $urandom};
                    addr_i[i*AW +: AW] = ($urandom_range(0, 5) == 0) ? EOC_ADDR : r64[AW-1:0];
                    wdata_i[i*DW +: DW] = {$urandom, $urandom};
                end
            end
            mem_gnt_i = ($urandom_range(0, 9) < 7);
            mem_rvalid_i = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_rdata_i = {$urandom, $urandom};
            cycle();
        end
        rst_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
